// File: rtl/io_out_uart_tx.sv
// Captures every change of the processor's 32-bit io_out word into a small FIFO
// and transmits each queued word as four 8N1 UART bytes, least significant byte first.
module io_out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_in,
    output logic        io_tx,
    output logic        io_busy,
    output logic        io_overflow,
    output logic [15:0] io_words_sent
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    logic [31:0]      last_q;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [15:0]      words_sent_q, words_sent_d;
    logic             busy_q, busy_d;

    logic push, pop, full, do_write;

    // FIFO bookkeeping: a push into a full FIFO only succeeds if a pop frees a slot on the same edge.
    always_comb begin
        push       = (io_in != last_q);
        pop        = (state_q == S_IDLE) && (count_q != '0);
        full       = (count_q == FIFO_FULL);
        do_write   = push && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full && !pop);
        if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_write, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        words_sent_d = words_sent_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    byte_idx_d = '0;
                    baud_d     = BIT_RELOAD;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d    = BIT_RELOAD;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            // The word shifts right once per data bit, so the next bit is always at shift_q[0].
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BIT_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        baud_d     = BIT_RELOAD;
                        tx_d       = 1'b0;
                        state_d    = S_START;
                    end else begin
                        words_sent_d = words_sent_q + 16'd1;
                        tx_d         = 1'b1;
                        state_d      = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            words_sent_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            last_q       <= io_in;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            words_sent_q <= words_sent_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_ptr_q] <= io_in;
    end

    assign io_tx         = tx_q;
    assign io_busy       = busy_q;
    assign io_overflow   = overflow_q;
    assign io_words_sent = words_sent_q;

endmodule

// File: tb/tb_io_out_uart_tx.sv
// Bench for io_out_uart_tx: expected bytes are queued when io_in is driven and
// compared by a UART receiver model that decodes io_tx.
module tb_io_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_in = '0;
    logic        io_tx;
    logic        io_busy;
    logic        io_overflow;
    logic [15:0] io_words_sent;

    io_out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in        (io_in),
        .io_tx        (io_tx),
        .io_busy      (io_busy),
        .io_overflow  (io_overflow),
        .io_words_sent(io_words_sent)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    bit          abort_mon = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives a new word at the next falling edge; queues its bytes when it is expected on the line.
    task automatic drive_word(input logic [31:0] v, input bit expect_sent);
        @(negedge clock);
        io_in = v;
        if (expect_sent) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clock);
        while (io_busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_idle_timeout"}, (n < 5000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // UART receiver: samples each bit mid-period, checks framing and pops the scoreboard.
    always begin : mon
        logic [7:0] b;
        bit         ok;
        @(negedge clock);
        if (!abort_mon && io_tx === 1'b0) begin
            start_q.push_back(cyc);
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clock);
            if (abort_mon) ok = 1'b0;
            if (ok) check_eq("start_bit", {31'd0, io_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                if (abort_mon) ok = 1'b0;
                b[i] = io_tx;
            end
            repeat (CPB) @(negedge clock);
            if (abort_mon) ok = 1'b0;
            if (ok) begin
                check_eq("stop_bit", {31'd0, io_tx}, 32'd1);
                check_eq("byte_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) check_eq("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int lows;
        int busys;
        int unsigned words_exp;

        reset = 1'b1;
        io_in = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_tx", {31'd0, io_tx}, 32'd1);
        check_eq("rst_busy", {31'd0, io_busy}, 32'd0);
        check_eq("rst_ovf", {31'd0, io_overflow}, 32'd0);
        check_eq("rst_words", {16'd0, io_words_sent}, 32'd0);
        reset = 1'b0;

        // Zero held after reset never produces a frame.
        lows = 0;
        busys = 0;
        repeat (200) begin
            @(negedge clock);
            if (io_tx !== 1'b1) lows++;
            if (io_busy !== 1'b0) busys++;
        end
        check_eq("t1_tx_low_cycles", lows, 0);
        check_eq("t1_busy_cycles", busys, 0);
        check_eq("t1_words", {16'd0, io_words_sent}, 32'd0);

        // Single word: latency, exact 160-cycle frame length.
        drive_word(32'h12345678, 1'b1);
        @(negedge clock);
        check_eq("t2_tx_push_edge", {31'd0, io_tx}, 32'd1);
        @(negedge clock);
        check_eq("t2_tx_fall", {31'd0, io_tx}, 32'd0);
        repeat (159) @(negedge clock);
        check_eq("t2_words_before_end", {16'd0, io_words_sent}, 32'd0);
        check_eq("t2_busy_before_end", {31'd0, io_busy}, 32'd1);
        @(negedge clock);
        check_eq("t2_words_end", {16'd0, io_words_sent}, 32'd1);
        check_eq("t2_busy_end", {31'd0, io_busy}, 32'd0);
        check_eq("t2_tx_end", {31'd0, io_tx}, 32'd1);
        check_eq("t2_all_bytes_seen", exp_q.size(), 0);

        // Three back-to-back words with a single idle cycle between them.
        start_q.delete();
        drive_word(32'h000000A5, 1'b1);
        drive_word(32'h0000005A, 1'b1);
        drive_word(32'h000000FF, 1'b1);
        wait_idle("t3");
        check_eq("t3_all_bytes_seen", exp_q.size(), 0);
        check_eq("t3_words", {16'd0, io_words_sent}, 32'd4);
        check_eq("t3_frame_count", start_q.size(), 12);
        if (start_q.size() >= 12) begin
            check_eq("t3_byte_spacing", start_q[1] - start_q[0], 40);
            check_eq("t3_word_gap_1", start_q[4] - start_q[0], 161);
            check_eq("t3_word_gap_2", start_q[8] - start_q[4], 161);
        end

        // Overflow: words 2..5 fill the FIFO while word 1 is on the line, word 6 is dropped.
        for (int v = 1; v <= 6; v++) drive_word(v, v <= 5);
        @(negedge clock);
        check_eq("t4_ovf_set", {31'd0, io_overflow}, 32'd1);
        wait_idle("t4");
        check_eq("t4_ovf_sticky", {31'd0, io_overflow}, 32'd1);
        check_eq("t4_words", {16'd0, io_words_sent}, 32'd9);
        check_eq("t4_all_bytes_seen", exp_q.size(), 0);

        // Reset during bit 3 of byte 1 (that bit is 0, so the asynchronous return to 1 is visible).
        drive_word(32'hCAFEB2BE, 1'b1);
        repeat (57) @(negedge clock);
        abort_mon = 1'b1;
        @(negedge clock);
        check_eq("t5_pre_tx", {31'd0, io_tx}, 32'd0);
        reset = 1'b1;
        io_in = '0;
        #1;
        check_eq("t5_async_tx", {31'd0, io_tx}, 32'd1);
        check_eq("t5_busy", {31'd0, io_busy}, 32'd0);
        check_eq("t5_words", {16'd0, io_words_sent}, 32'd0);
        check_eq("t5_ovf", {31'd0, io_overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        lows = 0;
        busys = 0;
        repeat (200) begin
            @(negedge clock);
            if (io_tx !== 1'b1) lows++;
            if (io_busy !== 1'b0) busys++;
        end
        abort_mon = 1'b0;
        check_eq("t5_no_frame", lows, 0);
        check_eq("t5_no_busy", busys, 0);

        // Word counter wrap.
        @(negedge clock);
        force dut.words_sent_q = 16'hFFFF;
        @(negedge clock);
        release dut.words_sent_q;
        words_exp = 0;
        check_eq("t6_preload", {16'd0, io_words_sent}, 32'h0000FFFF);
        drive_word(32'h0BADF00D, 1'b1);
        wait_idle("t6");
        check_eq("t6_wrap", {16'd0, io_words_sent}, words_exp);
        check_eq("t6_all_bytes_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_out_uart_tx.md
Name: io_out_uart_tx

Overview:
Transmit-side companion to the processor's 32-bit `io_out` port. It watches the word the processor drives and queues every new value in a small FIFO. Each queued value goes out as four 8N1 UART bytes on a single serial line, so a host or bench can log program output. It sits at the top level beside `TOP`, with its `io_in` wired to `TOP.io_out`.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period; legal values are ≥2.
FIFO_DEPTH, 4, number of 32-bit words buffered; must be a power of 2 and ≥2.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
io_in  input  32  processor output word (`TOP.io_out`).
io_tx  output  1  UART serial line; idles high.
io_busy  output  1  high while the FIFO is non-empty or a frame is in flight.
io_overflow  output  1  sticky flag; a changed word was dropped because the FIFO was full.
io_words_sent  output  16  count of words fully transmitted; wraps at 0xFFFF→0.

Behaviour:
- Reset values (applied asynchronously):
  - `io_tx`=1, `io_busy`=0, `io_overflow`=0, `io_words_sent`=0.
  - FIFO empty, FSM in IDLE, `last_q`=0x00000000.
- Change detect:
  - `last_q` <= `io_in` every cycle.
  - A push is requested on any edge where `io_in` != `last_q`; the value pushed is `io_in`.
  - No push while `io_in` equals its previous-cycle value.
  - A value of 0 held right after reset is never sent.
- FIFO:
  - Circular buffer with wrapping pointers and an occupancy count from 0 to FIFO_DEPTH.
  - Push while full and no pop on the same edge: the word is dropped and `io_overflow` <= 1. It stays set until reset.
  - Push and pop on the same edge while full: both happen, the count is unchanged, no overflow.
  - No bypass path: a word pushed into an empty FIFO is popped on the following edge at the earliest.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop on this edge, load the 32-bit shift word, set byte index=0, go to START.
  - START: `io_tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: `io_tx`=current byte bit[bit index], LSB first. Each bit lasts CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: `io_tx`=1 for CLKS_PER_BIT cycles. Then:
    - if byte index<3: byte index+1 and go directly to START, with no idle gap;
    - else: `io_words_sent`+1 and go to IDLE.
  - Byte order is little-endian: byte0=word[7:0] first, byte3=word[31:24] last.
- `io_tx` is a registered output.
  - Falls on the same edge the FSM leaves IDLE, i.e. one edge after the push edge for an empty FIFO.
  - One word occupies exactly 40*CLKS_PER_BIT cycles.
  - Back-to-back words: IDLE lasts exactly one cycle between the last STOP of one word and the START of the next, with `io_tx`=1 during that cycle.
- Bit timing uses a down-counter reloaded with CLKS_PER_BIT-1 at every bit boundary; there is no mid-bit drift.
- `io_busy` is registered and equals (FSM != IDLE) OR (FIFO count != 0), as evaluated after each edge.
- Reset asserted mid-frame: `io_tx` returns to 1 immediately (asynchronously), the partial frame is abandoned, and the FIFO contents are discarded.
- The 40-cycle count assumes one clock per frame bit; there is no parity and no configurable stop bits.

Test Plan:
1. Reset, then hold `io_in`=0 for 200 cycles -> `io_tx`=1 throughout, `io_busy`=0, `io_words_sent`=0.
2. CLKS_PER_BIT=4, step `io_in` to 0x12345678 and hold -> `io_tx` falls 1 cycle after the push edge. The decoded bytes are 0x78, 0x56, 0x34, 0x12, each framed 0/8 data/1. The frame lasts 160 cycles, then `io_words_sent`=1 and `io_busy`=0.
3. Drive 0xA5, 0x5A, 0xFF in three consecutive cycles -> three words are sent in order, separated by exactly 1 idle-high cycle, and `io_words_sent`=3.
4. FIFO_DEPTH=4: change `io_in` every cycle with 6 distinct values (1..6) while the TX is idle. Word 1 is popped at once, words 2–5 are queued, word 6 is dropped -> `io_overflow`=1, the words sent are 1,2,3,4,5, and `io_overflow` stays 1 after `io_busy` falls.
5. Assert `reset` for 1 cycle during bit 3 of byte1 -> `io_tx`=1 asynchronously, `io_busy`=0, counters are 0, and no further frame is sent until `io_in` changes.
6. Preload `io_words_sent` near wrap by sending 0x10000 words (or force it to 0xFFFF), then send one word -> `io_words_sent`=0x0000.
